// File: rtl/xilinx_distram_pkg.sv
// rtl/xilinx_distram_pkg.sv - shared state type and depth helper for the distributed-RAM read engine
package xilinx_distram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  function automatic int unsigned depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/xilinx_distram_skid.sv
// rtl/xilinx_distram_skid.sv - 2-entry ring buffer with push/pop and occupancy
module xilinx_distram_skid #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             head_q;
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;
  logic             tail_idx;

  always_comb begin
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // When full, a push is only legal alongside a pop, so it lands in the slot the head is vacating.
  assign tail_idx = head_q ^ (occ_q == 2'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[tail_idx] <= push_data_i;
      end
      if (pop_i) begin
        head_q <= ~head_q;
      end
      occ_q <= occ_d;
    end
  end

  assign head_data_o = mem_q[head_q];
  assign occ_o       = occ_q;

endmodule

// File: rtl/xilinx_dp_distram.sv
// rtl/xilinx_dp_distram.sv - dual-port LUT RAM: synchronous write on A/D/WE, async read on A and DPRA
module xilinx_dp_distram
  import xilinx_distram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  WCLK,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [ADDR_WIDTH-1:0] DPRA,
  output logic [DATA_WIDTH-1:0] SPO,
  output logic [DATA_WIDTH-1:0] DPO
);

  localparam int unsigned DEPTH = depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge WCLK) begin
    if (WE) begin
      mem_q[A] <= D;
    end
  end

  assign SPO = mem_q[A];
  assign DPO = mem_q[DPRA];

endmodule

// File: rtl/xilinx_distram_rd_stream.sv
// rtl/xilinx_distram_rd_stream.sv - burst reader for the LUT RAM async port, streamed through a 2-entry buffer
// Optional M_LAST output and per-entry tag bit enabled by DISTRAM_RD_LAST_EN.
module xilinx_distram_rd_stream
  import xilinx_distram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [ADDR_WIDTH-1:0] CMD_LEN,
  output logic [ADDR_WIDTH-1:0] DPRA,
  input  logic [DATA_WIDTH-1:0] DPO,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  BUSY
`ifdef DISTRAM_RD_LAST_EN
  ,
  output logic                  M_LAST
`endif
);

`ifdef DISTRAM_RD_LAST_EN
  localparam int BUF_W = DATA_WIDTH + 1;
`else
  localparam int BUF_W = DATA_WIDTH;
`endif

  rd_state_e             state_q;
  logic [ADDR_WIDTH-1:0] dpra_q;
  logic [ADDR_WIDTH-1:0] rem_q;
  logic                  busy_q;

  logic [1:0]       occ;
  logic             pop;
  logic             issue;
  logic [BUF_W-1:0] push_data;
  logic [BUF_W-1:0] head_data;

  assign M_VALID   = (occ != 2'd0);
  assign pop       = M_VALID && M_READY;
  assign issue     = (state_q == RUN) && ((occ != 2'd2) || pop);
  assign CMD_READY = (state_q == IDLE) && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      dpra_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (CMD_VALID) begin
            dpra_q  <= CMD_ADDR;
            rem_q   <= CMD_LEN;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            dpra_q <= dpra_q + ADDR_WIDTH'(1);
            rem_q  <= rem_q - ADDR_WIDTH'(1);
            if (rem_q == '0) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((occ == 2'd0) || ((occ == 2'd1) && pop)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DISTRAM_RD_LAST_EN
  assign push_data = {(rem_q == '0), DPO};
  assign M_LAST    = M_VALID && head_data[DATA_WIDTH];
`else
  assign push_data = DPO;
`endif

  xilinx_distram_skid #(
    .WIDTH(BUF_W)
  ) u_buf (
    .clk_i      (CLK),
    .rst_i      (RST),
    .push_i     (issue),
    .push_data_i(push_data),
    .pop_i      (pop),
    .head_data_o(head_data),
    .occ_o      (occ)
  );

  assign M_DATA = head_data[DATA_WIDTH-1:0];
  assign DPRA   = dpra_q;
  assign BUSY   = busy_q;

endmodule
